// File: rtl/mac_seq_ctrl_if.sv
// Job command, operand stream, MAC slice and result signals of the MAC sequencer.
// master = job source / MAC slice side, slave = mac_seq_ctrl.
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 10
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic        [LEN_W-1:0] cmd_len;
  logic signed [47:0]      cmd_bias;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [17:0]      s_x;
  logic signed [17:0]      s_y;
  logic signed [17:0]      dsp_x;
  logic signed [17:0]      dsp_y;
  logic signed [47:0]      dsp_c;
  logic                    dsp_sel;
  logic signed [47:0]      dsp_acc;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [47:0]      m_data;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_len, cmd_bias, s_valid, s_x, s_y, dsp_acc, m_ready,
    input  cmd_ready, s_ready, dsp_x, dsp_y, dsp_c, dsp_sel, m_valid, m_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_bias, s_valid, s_x, s_y, dsp_acc, m_ready,
    output cmd_ready, s_ready, dsp_x, dsp_y, dsp_c, dsp_sel, m_valid, m_data, busy
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 18x18+48 MAC slice: streams operand pairs, computes bias + sum(x*y),
// and returns the drained accumulator on a valid/ready result port.
//
// state  | meaning
// IDLE   | waiting for a job command
// STREAM | accepting operand pairs, zero pairs on stalls
// DRAIN  | waiting for the last pair to reach the accumulator
// HOLD   | result presented until consumed
module mac_seq_ctrl #(
  parameter int LEN_W = 10
) (
  input logic           clk,
  input logic           rst,
  mac_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic        [LEN_W-1:0] len_q, len_d;
  logic        [LEN_W-1:0] cnt_q, cnt_d;
  logic                    inject_q, inject_d;
  logic signed [17:0]      dsp_x_q, dsp_x_d;
  logic signed [17:0]      dsp_y_q, dsp_y_d;
  logic signed [47:0]      dsp_c_q, dsp_c_d;
  logic signed [47:0]      m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    first0_q, first0_d;
  logic                    last0_q, last0_d;
  logic                    last1_q, last2_q, dsp_sel_q;
  logic                    cmd_fire, s_fire;

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.s_ready   = (state_q == STREAM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dsp_x     = dsp_x_q;
  assign bus.dsp_y     = dsp_y_q;
  assign bus.dsp_c     = dsp_c_q;
  assign bus.dsp_sel   = dsp_sel_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign s_fire   = bus.s_valid && bus.s_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    inject_d  = inject_q;
    dsp_x_d   = '0;
    dsp_y_d   = '0;
    dsp_c_d   = dsp_c_q;
    first0_d  = 1'b0;
    last0_d   = 1'b0;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          len_d    = bus.cmd_len;
          dsp_c_d  = bus.cmd_bias;
          cnt_d    = '0;
          inject_d = (bus.cmd_len == '0);
          state_d  = (bus.cmd_len == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (s_fire) begin
          dsp_x_d  = bus.s_x;
          dsp_y_d  = bus.s_y;
          cnt_d    = cnt_q + LEN_W'(1);
          first0_d = (cnt_q == '0);
          last0_d  = (cnt_q == len_q - LEN_W'(1));
          if (last0_d) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // an empty job still needs one tagged zero pair so dsp_sel loads the bias
        if (inject_q) begin
          first0_d = 1'b1;
          last0_d  = 1'b1;
          inject_d = 1'b0;
        end
        if (last2_q) begin
          m_data_d  = bus.dsp_acc;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      inject_q  <= 1'b0;
      dsp_x_q   <= '0;
      dsp_y_q   <= '0;
      dsp_c_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      first0_q  <= 1'b0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
      dsp_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      inject_q  <= inject_d;
      dsp_x_q   <= dsp_x_d;
      dsp_y_q   <= dsp_y_d;
      dsp_c_q   <= dsp_c_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      first0_q  <= first0_d;
      last0_q   <= last0_d;
      // tags follow the pair: product stage, then accumulator stage
      last1_q   <= last0_q;
      last2_q   <= last1_q;
      dsp_sel_q <= first0_q;
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural MAC slice and a queue of expected results.
module tb_mac_seq_ctrl;
  localparam int LEN_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();
  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // MAC slice: product register, then accumulator (select 1 = product + C)
  logic signed [47:0] prod_q = '0;
  logic signed [47:0] acc_q  = '0;
  wire  signed [35:0] p36 = bus.dsp_x * bus.dsp_y;
  always @(posedge clk) begin
    prod_q <= {{12{p36[35]}}, p36};
    acc_q  <= bus.dsp_sel ? prod_q + bus.dsp_c : prod_q + acc_q;
  end
  assign bus.dsp_acc = acc_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel_seen = 0, sready_seen = 0;
  always @(negedge clk) begin
    if (bus.dsp_sel === 1'b1) sel_seen <= sel_seen + 1;
    if (bus.s_ready === 1'b1) sready_seen <= sready_seen + 1;
  end

  int checks = 0, errors = 0;
  logic [47:0] exp_q[$];
  int px[8], py[8];
  int stall_at = -1, stall_n = 0;
  int bubble_bad = 0;
  int cmd_edge = 0, last_edge = 0;

  function automatic logic [47:0] model(input int len, input logic [47:0] bias);
    logic [47:0] s;
    s = bias;
    for (int i = 0; i < len; i++) s = s + 48'(longint'(px[i]) * longint'(py[i]));
    return s;
  endfunction

  // all stimulus tasks are entered and left at a falling edge
  task automatic send_cmd(input int len, input logic [47:0] bias, output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_bias  = bias;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (bus.cmd_ready === 1'b1) begin ok = 1'b1; cmd_edge = cyc + 1; end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_pairs(input int n, output bit ok);
    bit got;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.s_valid = 1'b0;
        bus.s_x = '0;
        bus.s_y = '0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          if (bus.dsp_x !== 18'sd0 || bus.dsp_y !== 18'sd0) bubble_bad++;
        end
      end
      bus.s_valid = 1'b1;
      bus.s_x = 18'(px[i]);
      bus.s_y = 18'(py[i]);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        #1;
        if (bus.s_ready === 1'b1) begin got = 1'b1; last_edge = cyc + 1; end
        @(negedge clk);
      end
      if (!got) ok = 1'b0;
    end
    bus.s_valid = 1'b0;
    bus.s_x = '0;
    bus.s_y = '0;
  endtask

  task automatic run_job(input int len, input logic [47:0] bias, output bit ok);
    bit ok_c, ok_p;
    send_cmd(len, bias, ok_c);
    if (ok_c) exp_q.push_back(model(len, bias));
    send_pairs(len, ok_p);
    ok = ok_c && ok_p;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.m_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.s_ready !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready=%b s_ready=%b busy=%b m_valid=%b, required 0 0 0 0",
               bus.cmd_ready, bus.s_ready, bus.busy, bus.m_valid);
    end
    checks++;
    if (bus.dsp_x !== 18'sd0 || bus.dsp_y !== 18'sd0 || bus.dsp_c !== 48'sd0 || bus.dsp_sel !== 1'b0 || bus.m_data !== 48'sd0) begin
      errors++;
      $display("FAIL reset_data: x=%0h y=%0h c=%0h sel=%b m_data=%0h, required all 0",
               bus.dsp_x, bus.dsp_y, bus.dsp_c, bus.dsp_sel, bus.m_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int s0;
    logic [47:0] exp;
    for (int i = 0; i < 4; i++) begin px[i] = i + 1; py[i] = 2; end
    stall_at = -1;
    s0 = sel_seen;
    run_job(4, 48'd10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_accept: handshakes incomplete, required all accepted"); end
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.m_data !== exp) begin errors++; $display("FAIL basic_data: got %0d, required %0d", bus.m_data, exp); end
      checks++;
      if (cyc - last_edge != 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", cyc - last_edge); end
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: m_valid=%b, required 0", bus.m_valid); end
      checks++;
      if (sel_seen - s0 != 1) begin errors++; $display("FAIL basic_sel: got %0d sel cycles, required 1", sel_seen - s0); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int s0;
    logic [47:0] exp;
    for (int i = 0; i < 4; i++) begin px[i] = i + 1; py[i] = 2; end
    stall_at = 2;
    stall_n = 3;
    bubble_bad = 0;
    s0 = sel_seen;
    run_job(4, 48'd10, ok);
    stall_at = -1;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_accept: handshakes incomplete, required all accepted"); end
    checks++;
    if (bubble_bad != 0) begin errors++; $display("FAIL stall_bubble: %0d nonzero bubble cycles, required 0", bubble_bad); end
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.m_data !== exp) begin errors++; $display("FAIL stall_data: got %0d, required %0d", bus.m_data, exp); end
      checks++;
      if (cyc - last_edge != 3) begin errors++; $display("FAIL stall_latency: got %0d, required 3", cyc - last_edge); end
      @(negedge clk);
      checks++;
      if (sel_seen - s0 != 1) begin errors++; $display("FAIL stall_sel: got %0d sel cycles, required 1", sel_seen - s0); end
    end
  endtask

  task automatic test_len0();
    bit ok;
    int r0;
    logic [47:0] exp;
    r0 = sready_seen;
    run_job(0, -48'sd5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL len0_accept: cmd not accepted, required accepted"); end
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL len0_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.m_data !== exp) begin errors++; $display("FAIL len0_data: got %0h, required %0h", bus.m_data, exp); end
      checks++;
      if (cyc - cmd_edge != 4) begin errors++; $display("FAIL len0_latency: got %0d, required 4", cyc - cmd_edge); end
      @(negedge clk);
      checks++;
      if (sready_seen != r0) begin errors++; $display("FAIL len0_sready: s_ready seen %0d cycles, required 0", sready_seen - r0); end
    end
  endtask

  task automatic test_extremes();
    bit ok;
    logic [47:0] exp;
    px[0] = -131072; py[0] = -131072;
    run_job(1, 48'd0, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ext1_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.m_data !== exp) begin errors++; $display("FAIL ext1_data: got %0d, required %0d", bus.m_data, exp); end
    end
    @(negedge clk);
    px[0] = 131071; py[0] = 131071;
    px[1] = -1;     py[1] = 1;
    run_job(2, 48'd1, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ext2_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.m_data !== exp) begin errors++; $display("FAIL ext2_data: got %0d, required %0d", bus.m_data, exp); end
      checks++;
      if (cyc - last_edge != 3) begin errors++; $display("FAIL ext2_latency: got %0d, required 3", cyc - last_edge); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [47:0] exp;
    bus.m_ready = 1'b0;
    px[0] = 5; py[0] = 6;
    run_job(1, 48'd100, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LEN_W'(1);
      bus.cmd_bias  = 48'd0;
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== exp || bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_stable: cycle %0d m_valid=%b m_data=%0d cmd_ready=%b, required 1 %0d 0",
                   k, bus.m_valid, bus.m_data, bus.cmd_ready, exp);
        end
        @(negedge clk);
      end
      bus.m_ready = 1'b1;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_same_cycle: cmd_ready=%b, required 0", bus.cmd_ready); end
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL hold_release: m_valid=%b cmd_ready=%b, required 0 1", bus.m_valid, bus.cmd_ready);
      end
      px[0] = 2; py[0] = 3;
      exp_q.push_back(model(1, 48'd0));
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin
        errors++;
        $display("FAIL next_cmd: busy=%b s_ready=%b, required 1 1", bus.busy, bus.s_ready);
      end
      send_pairs(1, ok);
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL next_timeout: m_valid=0, required 1"); end
      else begin
        exp = exp_q.pop_front();
        checks++;
        if (bus.m_data !== exp) begin errors++; $display("FAIL next_data: got %0d, required %0d", bus.m_data, exp); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit ok;
    int mv;
    logic [47:0] exp;
    for (int i = 0; i < 4; i++) begin px[i] = i + 1; py[i] = 2; end
    send_cmd(4, 48'd10, ok);
    send_pairs(2, ok);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.s_ready !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0 ||
        bus.dsp_x !== 18'sd0 || bus.dsp_y !== 18'sd0 || bus.dsp_c !== 48'sd0 || bus.dsp_sel !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cmd_ready=%b s_ready=%b busy=%b m_valid=%b x=%0h y=%0h c=%0h sel=%b, required 0",
               bus.cmd_ready, bus.s_ready, bus.busy, bus.m_valid, bus.dsp_x, bus.dsp_y, bus.dsp_c, bus.dsp_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) mv++;
    end
    checks++;
    if (mv != 0) begin errors++; $display("FAIL reset_discard: m_valid seen %0d cycles, required 0", mv); end
    px[0] = 3; py[0] = 3;
    px[1] = 1; py[1] = 1;
    run_job(2, 48'd7, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fresh_timeout: m_valid=0, required 1"); end
    else begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.m_data !== exp) begin errors++; $display("FAIL fresh_data: got %0d, required %0d", bus.m_data, exp); end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_bias  = '0;
    bus.s_valid   = 1'b0;
    bus.s_x       = '0;
    bus.s_y       = '0;
    bus.m_ready   = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_extremes();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
